// File: rtl/rtc_pkg.sv
// Shared types, digit limits and hour helpers for the BCD real-time clock.
package rtc_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t h1;
    bcd_t h0;
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
  } rtc_time_t;

  localparam bcd_t S0Max  = 4'd9;
  localparam bcd_t S1Max  = 4'd5;
  localparam bcd_t M0Max  = 4'd9;
  localparam bcd_t M1Max  = 4'd5;
  localparam bcd_t H0Max  = 4'd9;
  localparam bcd_t H1Max  = 4'd2;
  localparam bcd_t DigMax = 4'd9;
  localparam bcd_t H1Last = 4'd2;
  localparam bcd_t H0Last = 4'd3;

  function automatic logic [6:0] hour_bin(input bcd_t h1, input bcd_t h0);
    return 7'(h1) * 7'd10 + 7'(h0);
  endfunction

  // Only meaningful for 0..23.
  function automatic logic [7:0] hour_bcd(input logic [6:0] hb);
    if (hb >= 7'd20) begin
      return {4'd2, 4'(hb - 7'd20)};
    end else if (hb >= 7'd10) begin
      return {4'd1, 4'(hb - 7'd10)};
    end else begin
      return {4'd0, hb[3:0]};
    end
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with load, synchronous clear and wrap at MAX.
module bcd_digit
  import rtc_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic ld,
  input  bcd_t ld_val,
  output bcd_t q,
  output bcd_t nxt,
  output logic carry
);

  always_comb begin
    nxt = q;
    if (ld) begin
      nxt = ld_val;
    end else if (clr) begin
      nxt = '0;
    end else if (en) begin
      nxt = (q == MAX) ? 4'd0 : q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

  assign carry = en & (q == MAX);

endmodule

// File: rtl/bcd_rtc.sv
// BCD real-time clock, 24-hour internal time with optional 12-hour display.
// Define BCD_RTC_ALARM_EN to add the alarm_time/alarm_en/alarm_ack/alarm ports.
module bcd_rtc
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        load,
  input  logic [23:0] set_time,
  input  logic        set_pm,
  input  logic        mode12,
  output logic [23:0] time_bcd,
  output logic        pm,
  output logic        sec_pulse,
  output logic        day_pulse,
  output logic        load_err
`ifdef BCD_RTC_ALARM_EN
  ,
  input  logic [23:0] alarm_time,
  input  logic        alarm_en,
  input  logic        alarm_ack,
  output logic        alarm
`endif
);

  localparam int unsigned PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PMax = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  rtc_time_t     cur, nxt_time, ld_time, st, disp;
  logic          tick, inc, load_ok, valid, hour_wrap;
  logic          c_s0, c_s1, c_m0, c_m1, c_h0, unused_c_h1;
  logic [6:0]    set_hb, ld_hb, nxt_hb, disp_hb;
  logic [23:0]   time_q;
  logic          pm_q, sec_q, day_q, err_q;

  assign st      = rtc_time_t'(set_time);
  assign tick    = run && (presc_q == PMax);
  assign load_ok = load && valid;
  assign inc     = tick && !load_ok;

  // Load validation and 12h->24h hour conversion.
  always_comb begin
    valid   = 1'b0;
    ld_hb   = '0;
    ld_time = st;
    set_hb  = hour_bin(st.h1, st.h0);
    if (st.s0 <= DigMax && st.s1 <= S1Max && st.m0 <= DigMax && st.m1 <= M1Max &&
        st.h0 <= DigMax && st.h1 <= H1Max) begin
      valid = mode12 ? (set_hb >= 7'd1 && set_hb <= 7'd12) : (set_hb <= 7'd23);
    end
    if (!mode12) begin
      ld_hb = set_hb;
    end else if (set_hb == 7'd12) begin
      ld_hb = set_pm ? 7'd12 : 7'd0;
    end else begin
      ld_hb = set_pm ? set_hb + 7'd12 : set_hb;
    end
    {ld_time.h1, ld_time.h0} = hour_bcd(ld_hb);
  end

  always_comb begin
    presc_d = presc_q;
    if (load_ok) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  assign hour_wrap = c_m1 && (cur.h1 == H1Last) && (cur.h0 == H0Last);

  bcd_digit #(.MAX(S0Max)) u_s0 (
    .clk(clk), .rst_n(rst_n), .en(inc), .clr(1'b0), .ld(load_ok), .ld_val(ld_time.s0),
    .q(cur.s0), .nxt(nxt_time.s0), .carry(c_s0)
  );
  bcd_digit #(.MAX(S1Max)) u_s1 (
    .clk(clk), .rst_n(rst_n), .en(c_s0), .clr(1'b0), .ld(load_ok), .ld_val(ld_time.s1),
    .q(cur.s1), .nxt(nxt_time.s1), .carry(c_s1)
  );
  bcd_digit #(.MAX(M0Max)) u_m0 (
    .clk(clk), .rst_n(rst_n), .en(c_s1), .clr(1'b0), .ld(load_ok), .ld_val(ld_time.m0),
    .q(cur.m0), .nxt(nxt_time.m0), .carry(c_m0)
  );
  bcd_digit #(.MAX(M1Max)) u_m1 (
    .clk(clk), .rst_n(rst_n), .en(c_m0), .clr(1'b0), .ld(load_ok), .ld_val(ld_time.m1),
    .q(cur.m1), .nxt(nxt_time.m1), .carry(c_m1)
  );
  bcd_digit #(.MAX(H0Max)) u_h0 (
    .clk(clk), .rst_n(rst_n), .en(c_m1), .clr(hour_wrap), .ld(load_ok), .ld_val(ld_time.h0),
    .q(cur.h0), .nxt(nxt_time.h0), .carry(c_h0)
  );
  bcd_digit #(.MAX(H1Max)) u_h1 (
    .clk(clk), .rst_n(rst_n), .en(c_h0), .clr(hour_wrap), .ld(load_ok), .ld_val(ld_time.h1),
    .q(cur.h1), .nxt(nxt_time.h1), .carry(unused_c_h1)
  );

  // Display is built from next-state so it updates on the same edge as the time.
  always_comb begin
    disp    = nxt_time;
    nxt_hb  = hour_bin(nxt_time.h1, nxt_time.h0);
    disp_hb = nxt_hb;
    if (mode12) begin
      if (nxt_hb == 7'd0) begin
        disp_hb = 7'd12;
      end else if (nxt_hb > 7'd12) begin
        disp_hb = nxt_hb - 7'd12;
      end
    end
    {disp.h1, disp.h0} = hour_bcd(disp_hb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      time_q  <= '0;
      pm_q    <= 1'b0;
      sec_q   <= 1'b0;
      day_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      time_q  <= disp;
      pm_q    <= (nxt_hb >= 7'd12);
      sec_q   <= inc;
      day_q   <= hour_wrap;
      err_q   <= load && !valid;
    end
  end

  assign time_bcd  = time_q;
  assign pm        = pm_q;
  assign sec_pulse = sec_q;
  assign day_pulse = day_q;
  assign load_err  = err_q;

`ifdef BCD_RTC_ALARM_EN
  logic alarm_q;

  // Ack has priority over a simultaneous match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else if (alarm_ack) begin
      alarm_q <= 1'b0;
    end else if (inc && alarm_en && (nxt_time == rtc_time_t'(alarm_time))) begin
      alarm_q <= 1'b1;
    end
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_bcd_rtc.sv
// Directed, table-driven bench for bcd_rtc with CLK_HZ=4.
module tb_bcd_rtc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        load;
  logic [23:0] set_time;
  logic        set_pm;
  logic        mode12;
  logic [23:0] time_bcd;
  logic        pm;
  logic        sec_pulse;
  logic        day_pulse;
  logic        load_err;
`ifdef BCD_RTC_ALARM_EN
  logic [23:0] alarm_time;
  logic        alarm_en;
  logic        alarm_ack;
  logic        alarm;
`endif

  int checks = 0;
  int failures = 0;

  bcd_rtc #(.CLK_HZ(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load), .set_time(set_time),
    .set_pm(set_pm), .mode12(mode12), .time_bcd(time_bcd), .pm(pm),
    .sec_pulse(sec_pulse), .day_pulse(day_pulse), .load_err(load_err)
`ifdef BCD_RTC_ALARM_EN
    , .alarm_time(alarm_time), .alarm_en(alarm_en), .alarm_ack(alarm_ack), .alarm(alarm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ld;
    logic [23:0] st;
    logic        spm;
    logic        m12;
    logic [23:0] exp_time;
    logic        exp_pm;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_pulses(input string name, input logic s, input logic d, input logic e);
    check({name, ".sec"}, {31'd0, sec_pulse}, {31'd0, s});
    check({name, ".day"}, {31'd0, day_pulse}, {31'd0, d});
    check({name, ".err"}, {31'd0, load_err}, {31'd0, e});
  endtask

  initial begin
    vecs[0]  = '{1'b1, 24'h235958, 1'b0, 1'b0, 24'h235958, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 24'h256000, 1'b0, 1'b0, 24'h235958, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 24'h000000, 1'b0, 1'b1, 24'h115958, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 24'h120000, 1'b0, 1'b1, 24'h120000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 24'h010500, 1'b1, 1'b1, 24'h010500, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 24'h130500, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 24'h126000, 1'b0, 1'b0, 24'h130500, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 24'h0A0000, 1'b0, 1'b0, 24'h130500, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 24'h240000, 1'b0, 1'b0, 24'h130500, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 24'h120000, 1'b1, 1'b1, 24'h120000, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 24'h000000, 1'b0, 1'b0, 24'h120000, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 24'h110000, 1'b1, 1'b1, 24'h110000, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 24'h000000, 1'b0, 1'b0, 24'h230000, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 24'h130000, 1'b0, 1'b1, 24'h110000, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 24'h095959, 1'b0, 1'b1, 24'h095959, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 24'h000000, 1'b0, 1'b0, 24'h095959, 1'b0, 1'b0};

    rst_n = 1'b0; run = 1'b0; load = 1'b0; set_time = '0; set_pm = 1'b0; mode12 = 1'b1;
`ifdef BCD_RTC_ALARM_EN
    alarm_time = '0; alarm_en = 1'b0; alarm_ack = 1'b0;
`endif

    // Reset state, then first cycle after release in 12-hour mode.
    #12;
    check("rst.time", {8'd0, time_bcd}, 32'h000000);
    check("rst.pm", {31'd0, pm}, 32'd0);
    check_pulses("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check("rel12.time", {8'd0, time_bcd}, 32'h120000);
    check("rel12.pm", {31'd0, pm}, 32'd0);

    // Table: loads, validation and display conversion with the clock held.
    for (int i = 0; i < 17; i++) begin
      load = vecs[i].ld; set_time = vecs[i].st; set_pm = vecs[i].spm; mode12 = vecs[i].m12;
      step();
      load = 1'b0;
      check($sformatf("vec%0d.time", i), {8'd0, time_bcd}, {8'd0, vecs[i].exp_time});
      check($sformatf("vec%0d.pm", i), {31'd0, pm}, {31'd0, vecs[i].exp_pm});
      check_pulses($sformatf("vec%0d", i), 1'b0, 1'b0, vecs[i].exp_err);
    end
    mode12 = 1'b0; set_pm = 1'b0;

    // Second and midnight rollover.
    load = 1'b1; set_time = 24'h235958; run = 1'b1;
    step();
    load = 1'b0;
    check("roll.load", {8'd0, time_bcd}, 32'h235958);
    check_pulses("roll.load", 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 4) begin
        check("roll.s59", {8'd0, time_bcd}, 32'h235959);
        check_pulses("roll.s59", 1'b1, 1'b0, 1'b0);
      end else if (i == 8) begin
        check("roll.mid", {8'd0, time_bcd}, 32'h000000);
        check("roll.pm", {31'd0, pm}, 32'd0);
        check_pulses("roll.mid", 1'b1, 1'b1, 1'b0);
      end else begin
        check($sformatf("roll.q%0d", i), {31'd0, sec_pulse}, 32'd0);
      end
    end

    // Hold with run=0.
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("hold%0d", i), {7'd0, sec_pulse, time_bcd}, 32'h000000);
    end

    // Load coincident with prescaler wrap wins; prescaler restarts.
    run = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("wrap.pre", {7'd0, sec_pulse, time_bcd}, 32'h000000);
    load = 1'b1; set_time = 24'h101010;
    step();
    load = 1'b0;
    check("wrap.load", {8'd0, time_bcd}, 32'h101010);
    check_pulses("wrap.load", 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) check($sformatf("wrap.q%0d", i), {31'd0, sec_pulse}, 32'd0);
    end
    check("wrap.tick", {7'd0, sec_pulse, time_bcd}, {8'h01, 24'h101011});

    // Asynchronous reset mid-count discards a pending load and tick.
    for (int i = 0; i < 2; i++) step();
    load = 1'b1; set_time = 24'h222222;
    #1 rst_n = 1'b0;
    #1;
    check("arst.time", {8'd0, time_bcd}, 32'h000000);
    check("arst.pm", {31'd0, pm}, 32'd0);
    check_pulses("arst", 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) check($sformatf("arst.q%0d", i), {7'd0, sec_pulse, time_bcd}, 32'h000000);
    end
    check("arst.first", {7'd0, sec_pulse, time_bcd}, {8'h01, 24'h000001});

`ifdef BCD_RTC_ALARM_EN
    alarm_time = 24'h000002; alarm_en = 1'b1;
    load = 1'b1; set_time = 24'h000000;
    step();
    load = 1'b0;
    check("alm.load", {31'd0, alarm}, 32'd0);
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i < 8) check($sformatf("alm.lo%0d", i), {31'd0, alarm}, 32'd0);
      else check($sformatf("alm.hi%0d", i), {31'd0, alarm}, 32'd1);
    end
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    check("alm.ack", {31'd0, alarm}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_rtc.md
BCD_RTC -- requirements
Module: bcd_rtc

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 100_000_000, giving the clk cycles per counted second (minimum 2).
REQ-002 The module SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The module SHALL have port run  input  1  1 = count seconds, 0 = hold time and prescaler.
REQ-005 The module SHALL have port load  input  1  one-cycle request to load set_time/set_pm.
REQ-006 The module SHALL have port set_time  input  24  BCD {H1,H0,M1,M0,S1,S0}, interpreted per mode12.
REQ-007 The module SHALL have port set_pm  input  1  PM flag for load in 12-hour mode; ignored in 24-hour mode.
REQ-008 The module SHALL have port mode12  input  1  0 = 24-hour display, 1 = 12-hour display.
REQ-009 The module SHALL have port time_bcd  output  24  registered BCD time in the selected mode.
REQ-010 The module SHALL have port pm  output  1  1 when internal hour >= 12, in both modes.
REQ-011 The module SHALL have port sec_pulse  output  1  one-cycle pulse per counted second.
REQ-012 The module SHALL have port day_pulse  output  1  one-cycle pulse on midnight wrap.
REQ-013 The module SHALL have port load_err  output  1  one-cycle pulse on a rejected load.

Function
REQ-014 Internal time SHALL be held in 24-hour BCD; prescaler SHALL count 0..CLK_HZ-1 while run=1 and hold while run=0.
REQ-015 When the prescaler reaches CLK_HZ-1 it SHALL wrap to 0, and on that same edge seconds SHALL advance with full carry through S0 (0-9), S1 (0-5), M0, M1, and hours (00-23).
REQ-016 sec_pulse SHALL be high in the cycle in which time_bcd first shows the new value; day_pulse likewise on 23:59:59 -> 00:00:00.
REQ-017 Load validation: S1<=5, S0<=9, M1<=5, M0<=9, all digits <=9; hours 00-23 in 24-hour mode, 01-12 in 12-hour mode.
REQ-018 A valid load SHALL replace time on the next edge, clear the prescaler, and suppress sec_pulse/day_pulse for that cycle.
REQ-019 In 12-hour mode the loaded hour SHALL be converted to internal form: 12 with set_pm=0 -> 00, 12 with set_pm=1 -> 12, h with set_pm=1 -> h+12.
REQ-020 An invalid load SHALL leave time and prescaler unchanged and pulse load_err for one cycle.
REQ-021 A load coincident with a prescaler wrap SHALL win; no increment is applied.
REQ-022 Display conversion with mode12=1: internal 00 -> 12, 01-12 unchanged, 13-23 -> h-12. A mode12 change SHALL appear on time_bcd one cycle later.

Reset
REQ-023 rst_n low SHALL immediately clear the prescaler, internal time, and all outputs: time_bcd = 000000 (24-hour mode) or 120000 on the first cycle after release in 12-hour mode, with pm, sec_pulse, day_pulse, load_err and alarm all 0.
REQ-024 Reset asserted mid-count SHALL discard any pending tick or load.

Configuration
REQ-025 With macro BCD_RTC_ALARM_EN defined, the module SHALL add ports alarm_time (input 24, internal 24-hour BCD), alarm_en (input 1), alarm_ack (input 1), and alarm (output 1).
REQ-026 With the macro defined, alarm SHALL set when an increment makes the time equal to alarm_time while alarm_en=1, and hold until alarm_ack=1. A load never sets alarm, and ack wins over a simultaneous set.
REQ-027 Without the macro, these ports and their logic SHALL be absent.

Structure
REQ-028 Package rtc_pkg SHALL hold the BCD digit typedef, the packed time struct typedef {h1,h0,m1,m0,s1,s0}, and the digit-limit constants.
REQ-029 Sub-module bcd_digit SHALL implement one BCD digit with parameter MAX, inputs en and clr, and outputs q and carry (en & q==MAX). It SHALL be instantiated six times, with the hour-pair 23 wrap handled in bcd_rtc.

Verification (CLK_HZ=4)
REQ-030 Pulse rst_n low mid-count -> time_bcd=000000 and all pulses 0 at once; first sec_pulse exactly 4 cycles after release with run=1.
REQ-031 Load 235958 (24-hour), run=1 -> 235959 with sec_pulse after 4 cycles; 000000 with sec_pulse and day_pulse after 8 cycles.
REQ-032 Load 256000, then hour 00 with mode12=1 -> load_err pulses each time and time is unchanged. Load 12xxxx with mode12=1 and set_pm=0 -> internal 00.
REQ-033 Internal 130500, mode12=1 -> time_bcd=010500 and pm=1; internal 000000 -> 120000 and pm=0.
REQ-034 run=0 holds time for 20 cycles. A load on the wrap cycle -> loaded value shown and no sec_pulse.
REQ-035 With BCD_RTC_ALARM_EN: alarm_time=000002, load 000000 -> alarm rises with the 2nd sec_pulse and stays high until alarm_ack. Without the macro, the ports are absent and the design elaborates.
